stream_scoreboard: RTL and testbench

STREAM_SCOREBOARD -- requirements
Module: stream_scoreboard

---
 rtl/stream_common_pkg.sv | 37 +++
 rtl/stream_sb_fifo.sv | 45 ++++
 rtl/stream_scoreboard.sv | 149 ++++++++++++++
 tb/tb_stream_scoreboard.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_common_pkg.sv
// stream_common -- shared symbol-layout helpers and scoreboard state type.
// Rev 1.0
`default_nettype none

package stream_common;

  localparam int MaxSymbols = 16;

  typedef logic [MaxSymbols*32-1:0] sym_bits_t;

  typedef enum logic [0:0] {
    SB_RUN  = 1'b0,
    SB_FAIL = 1'b1
  } sb_state_e;

  // Sum of the first num symbol widths, each packed as a 32-bit slice.
  function automatic int calc_total(input sym_bits_t bits, input int num);
    int total;
    total = 0;
    for (int i = 0; i < MaxSymbols; i++) begin
      if (i < num) total += int'(bits[i*32 +: 32]);
    end
    return total;
  endfunction

  function automatic int calc_offset(input sym_bits_t bits, input int idx);
    int off;
    off = 0;
    for (int i = 0; i < MaxSymbols; i++) begin
      if (i < idx) off += int'(bits[i*32 +: 32]);
    end
    return off;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_sb_fifo.sv
// stream_sb_fifo -- expected-word buffer with wrap-around pointers (extra MSB).
// Rev 1.0
`default_nettype none

module stream_sb_fifo #(
  parameter int Width = 11,
  parameter int Depth = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int Aw = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [Aw:0]      wr_ptr;
  logic [Aw:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[Aw] != rd_ptr[Aw]) && (wr_ptr[Aw-1:0] == rd_ptr[Aw-1:0]);
  assign head  = mem[rd_ptr[Aw-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[Aw-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_scoreboard.sv
// stream_scoreboard -- in-order expected-vs-observed stream checker; watchdog
// built only with macro STREAM_SCOREBOARD_TIMEOUT_EN. Rev 1.0
`default_nettype none

module stream_scoreboard
  import stream_common::*;
#(
  parameter int                       NumSymbols    = 2,
  parameter logic [NumSymbols*32-1:0] SymbolBits    = {32'd8, 32'd2},
  parameter int                       Depth         = 16,
  parameter int                       StopOnError   = 0,
  parameter int                       TimeoutCycles = 1024,
  parameter int                       CountBits     = 16,
  localparam int                      W             = calc_total(sym_bits_t'(SymbolBits), NumSymbols)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  input  logic [W-1:0]          exp_data,
  input  logic                  exp_last,
  input  logic                  din_valid,
  input  logic                  din_ready,
  input  logic [W-1:0]          din_data,
  input  logic                  din_last,
  output logic [NumSymbols-1:0] sym_mismatch,
  output logic                  mismatch,
  output logic [CountBits-1:0]  match_count,
  output logic [CountBits-1:0]  err_count,
  output logic                  done,
  output logic                  err,
  output logic                  timeout
);

  localparam sym_bits_t SymBitsExt = sym_bits_t'(SymbolBits);

  sb_state_e             state;
  sb_state_e             state_next;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  txn;
  logic                  underflow;
  logic                  last_diff;
  logic                  cmp_bad;
  logic                  clean;
  logic                  err_event;
  logic                  wd_trip;
  logic [W:0]            head;
  logic [NumSymbols-1:0] sym_diff;
  logic [NumSymbols-1:0] sym_next;

  assign exp_ready = rst_n & ~full & (state == SB_RUN);
  assign push      = exp_valid & exp_ready;
  assign txn       = din_valid & din_ready & (state == SB_RUN);
  assign underflow = txn & empty;
  assign pop       = txn & ~empty;

  stream_sb_fifo #(
    .Width (W + 1),
    .Depth (Depth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({exp_last, exp_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Case inequality so that X/Z on either side counts as a mismatch.
  for (genvar g = 0; g < NumSymbols; g++) begin : g_sym
    localparam int Off = calc_offset(SymBitsExt, g);
    localparam int Sw  = int'(SymBitsExt[g*32 +: 32]);
    assign sym_diff[g] = (head[Off +: Sw] !== din_data[Off +: Sw]);
  end

  assign last_diff = (head[W] !== din_last);

  always_comb begin
    sym_next = sym_diff;
    if (underflow || last_diff) sym_next = '1;
  end

  assign cmp_bad   = txn & (|sym_next);
  assign clean     = txn & ~(|sym_next);
  assign err_event = cmp_bad | wd_trip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_mismatch <= '0;
      mismatch     <= 1'b0;
      match_count  <= '0;
      err_count    <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      mismatch <= cmp_bad;
      if (txn) sym_mismatch <= sym_next;
      if (clean && (match_count != '1)) match_count <= match_count + 1'b1;
      if (err_event && (err_count != '1)) err_count <= err_count + 1'b1;
      if (pop && head[W]) done <= 1'b1;
      if (err_event) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SB_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if ((state == SB_RUN) && (StopOnError != 0) && err_event) state_next = SB_FAIL;
  end

`ifdef STREAM_SCOREBOARD_TIMEOUT_EN
  localparam int WdBits = $clog2(TimeoutCycles + 1);

  logic [WdBits-1:0] wd_count;
  logic              wd_active;
  logic              timeout_q;

  // The trip fires on the cycle the count would reach TimeoutCycles.
  assign wd_active = ~empty & ~txn & (state == SB_RUN);
  assign wd_trip   = wd_active && (wd_count == WdBits'(TimeoutCycles - 1));
  assign timeout   = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_count  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (txn || wd_trip) wd_count <= '0;
      else if (wd_active) wd_count <= wd_count + 1'b1;
      if (wd_trip) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_trip = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_scoreboard.sv
// tb_stream_scoreboard -- directed and random checks against a queue-based model.
// Rev 1.0
`default_nettype none

module tb_stream_scoreboard;

  localparam int W      = 10;
  localparam int DEPTH  = 16;
  localparam int MAXC   = 65535;
  localparam int TO0    = 1024;
  localparam int SYM_W [2] = '{2, 8};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic exp_valid = 1'b0, exp_last = 1'b0;
  logic din_valid = 1'b0, din_ready = 1'b0, din_last = 1'b0;
  logic [W-1:0] exp_data = '0, din_data = '0;

  logic        rdy0, rdy1, rdy2;
  logic [1:0]  sym0, sym1, sym2;
  logic        mis0, mis1, mis2;
  logic [15:0] mc0, mc1, mc2, ec0, ec1, ec2;
  logic        done0, done1, done2, err0, err1, err2, to0, to1, to2;

  stream_scoreboard dut0 (
    .clk(clk), .rst_n(rst_n), .exp_valid(exp_valid), .exp_ready(rdy0), .exp_data(exp_data),
    .exp_last(exp_last), .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .din_last(din_last), .sym_mismatch(sym0), .mismatch(mis0), .match_count(mc0),
    .err_count(ec0), .done(done0), .err(err0), .timeout(to0));

  stream_scoreboard #(.StopOnError(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .exp_valid(exp_valid), .exp_ready(rdy1), .exp_data(exp_data),
    .exp_last(exp_last), .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .din_last(din_last), .sym_mismatch(sym1), .mismatch(mis1), .match_count(mc1),
    .err_count(ec1), .done(done1), .err(err1), .timeout(to1));

  stream_scoreboard #(.TimeoutCycles(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .exp_valid(exp_valid), .exp_ready(rdy2), .exp_data(exp_data),
    .exp_last(exp_last), .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .din_last(din_last), .sym_mismatch(sym2), .mismatch(mis2), .match_count(mc2),
    .err_count(ec2), .done(done2), .err(err2), .timeout(to2));

  always #5 clk = ~clk;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  // Reference model for dut0.
  logic [W:0] q [$];
  int         m_match, m_err, m_wd;
  bit         m_done, m_errf, m_mis, m_to;
  logic [1:0] m_sym;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] ref_sym(input logic [W:0] e, input logic [W:0] o);
    logic [1:0] r;
    int base, ed, od, m;
    base = 1;
    ed = int'(e[W-1:0]);
    od = int'(o[W-1:0]);
    for (int i = 0; i < 2; i++) begin
      m = 1 << SYM_W[i];
      r[i] = ((ed / base) % m) != ((od / base) % m);
      base = base * m;
    end
    if (e[W] != o[W]) r = 2'b11;
    return r;
  endfunction

  task automatic model_clear();
    q.delete();
    m_match = 0; m_err = 0; m_wd = 0;
    m_done = 0; m_errf = 0; m_mis = 0; m_to = 0; m_sym = 2'b00;
  endtask

  task automatic tick();
    bit ready, push, txn;
    int qs;
    logic [W:0] obs, hd, pw;
    logic [1:0] s;
    ready = (rst_n === 1'b1) && (q.size() < DEPTH);
    chk("exp_ready", 32'(rdy0), 32'(ready));
    push = exp_valid && ready;
    txn  = din_valid && din_ready;
    obs  = {din_last, din_data};
    pw   = {exp_last, exp_data};
    qs   = q.size();
    @(posedge clk);
    m_mis = 0;
    if (txn) begin
      if (qs == 0) s = 2'b11;
      else begin
        hd = q.pop_front();
        s = ref_sym(hd, obs);
        if (hd[W]) m_done = 1;
      end
      m_sym = s;
      if (s != 2'b00) begin
        m_mis = 1; m_errf = 1;
        if (m_err < MAXC) m_err++;
      end else if (m_match < MAXC) m_match++;
      m_wd = 0;
    end
`ifdef STREAM_SCOREBOARD_TIMEOUT_EN
    if (!txn && qs != 0) begin
      m_wd++;
      if (m_wd == TO0) begin
        m_wd = 0; m_to = 1; m_errf = 1;
        if (m_err < MAXC) m_err++;
      end
    end
`endif
    if (push) q.push_back(pw);
    #1;
    chk("mismatch", 32'(mis0), 32'(m_mis));
    chk("sym_mismatch", 32'(sym0), 32'(m_sym));
    chk("match_count", 32'(mc0), 32'(m_match));
    chk("err_count", 32'(ec0), 32'(m_err));
    chk("done", 32'(done0), 32'(m_done));
    chk("err", 32'(err0), 32'(m_errf));
    chk("timeout", 32'(to0), 32'(m_to));
  endtask

  task automatic do_reset();
    exp_valid = 0; exp_last = 0; din_valid = 0; din_ready = 0; din_last = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_exp_ready", 32'(rdy0), 32'd0);
    chk("rst_sym", 32'(sym0), 32'd0);
    chk("rst_mismatch", 32'(mis0), 32'd0);
    chk("rst_match", 32'(mc0), 32'd0);
    chk("rst_err_count", 32'(ec0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_timeout2", 32'(to2), 32'd0);
    chk("rst_err_count2", 32'(ec2), 32'd0);
    chk("rst_err2", 32'(err2), 32'd0);
    chk("rst_exp_ready1", 32'(rdy1), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d, input logic l);
    exp_valid = 1; exp_data = d; exp_last = l;
    tick();
    exp_valid = 0; exp_last = 0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic l);
    din_valid = 1; din_ready = 1; din_data = d; din_last = l;
    tick();
    din_valid = 0; din_ready = 0; din_last = 0;
  endtask

  initial begin
    #2;
    do_reset();

    // Four clean words, last on the fourth.
    for (int i = 0; i < 4; i++) push_word(W'(12'h100 + i), i == 3);
    for (int i = 0; i < 4; i++) send_word(W'(12'h100 + i), i == 3);
    tick();
    chk("basic_match", 32'(mc0), 32'd4);
    chk("basic_errc", 32'(ec0), 32'd0);
    chk("basic_done", 32'(done0), 32'd1);
    chk("basic_err", 32'(err0), 32'd0);

    // Symbol 0 differs.
    do_reset();
    push_word(10'h2A5, 1'b1);
    send_word(10'h2A6, 1'b1);
    chk("sym0_mask", 32'(sym0), 32'd1);
    chk("sym0_pulse", 32'(mis0), 32'd1);
    tick();
    chk("sym0_pulse_end", 32'(mis0), 32'd0);
    chk("sym0_err", 32'(err0), 32'd1);
    chk("sym0_errc", 32'(ec0), 32'd1);

    // Underflow, then a normal word shows nothing was popped.
    do_reset();
    send_word(10'h055, 1'b0);
    chk("uflow_mask", 32'(sym0), 32'd3);
    chk("uflow_errc", 32'(ec0), 32'd1);
    push_word(10'h055, 1'b1);
    send_word(10'h055, 1'b1);
    chk("uflow_then_match", 32'(mc0), 32'd1);

    // Stop-on-error instance: error on word 2 of 5.
    do_reset();
    for (int i = 0; i < 5; i++) push_word(W'(8'h10 + i), i == 4);
    send_word(10'h010, 1'b0);
    send_word(10'h3FF, 1'b0);
    send_word(10'h012, 1'b0);
    send_word(10'h013, 1'b0);
    send_word(10'h014, 1'b1);
    tick();
    chk("stop_ready", 32'(rdy1), 32'd0);
    chk("stop_match", 32'(mc1), 32'd1);
    chk("stop_errc", 32'(ec1), 32'd1);
    chk("stop_err", 32'(err1), 32'd1);
    chk("nostop_match", 32'(mc0), 32'd4);

    // Fill to depth, then drain through the wrap.
    do_reset();
    for (int i = 0; i < 16; i++) push_word(W'((i * 37) % 1024), i == 15);
    chk("full_ready", 32'(rdy0), 32'd0);
    push_word(10'h3AB, 1'b0);
    for (int i = 0; i < 16; i++) send_word(W'((i * 37) % 1024), i == 15);
    chk("wrap_match", 32'(mc0), 32'd16);
    chk("wrap_done", 32'(done0), 32'd1);
    chk("wrap_errc", 32'(ec0), 32'd0);

    // Watchdog on the 8-cycle instance, then a mid-stream reset.
    do_reset();
    push_word(10'h123, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      tick();
`ifdef STREAM_SCOREBOARD_TIMEOUT_EN
      chk("wd_timeout", 32'(to2), 32'(j >= 8));
      chk("wd_errc", 32'(ec2), 32'(j >= 8));
`endif
    end
    repeat (3) tick();
`ifdef STREAM_SCOREBOARD_TIMEOUT_EN
    chk("wd_errc_once", 32'(ec2), 32'd1);
    chk("wd_err", 32'(err2), 32'd1);
`else
    chk("wd_absent_to", 32'(to2), 32'd0);
    chk("wd_absent_errc", 32'(ec2), 32'd0);
`endif
    do_reset();
    send_word(10'h123, 1'b1);
    chk("flush_uflow", 32'(sym0), 32'd3);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      exp_valid = 1'($urandom_range(0, 1));
      exp_data  = W'($urandom);
      exp_last  = ($urandom_range(0, 7) == 0);
      din_valid = ($urandom_range(0, 9) < 7);
      din_ready = ($urandom_range(0, 9) < 8);
      if (q.size() != 0 && $urandom_range(0, 3) != 0) begin
        din_data = q[0][W-1:0];
        din_last = q[0][W];
      end else begin
        din_data = W'($urandom);
        din_last = 1'($urandom_range(0, 1));
      end
      tick();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
